// File: rtl/mult_fu_cdb_stage.sv
// Pipelined integer multiplier feeding the CDB arbiter.
// Bubble-collapsing stages; result broadcast one cycle after grant.
package mult_fu_pkg;
    localparam int CDB_XLEN  = 32;
    localparam int CDB_TAG_W = 6;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [CDB_XLEN-1:0]  data;
    } CDB_ENTRY;
endpackage

module mult_fu_cdb_stage
    import mult_fu_pkg::*;
#(
    parameter int XLEN   = CDB_XLEN,
    parameter int STAGES = 4,
    parameter int TAG_W  = CDB_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [XLEN-1:0]  issue_rs1,
    input  logic [XLEN-1:0]  issue_rs2,
    input  logic [1:0]       issue_func,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             flush,
    output logic             cdb_request,
    input  logic             cdb_grant,
    output CDB_ENTRY         fu_output
);
    localparam int PW   = 2 * XLEN;
    localparam int SL   = PW / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag    [STAGES];
    logic [1:0]        r_func   [STAGES];
    logic [PW-1:0]     r_acc    [STAGES];
    logic [PW-1:0]     r_mcand  [STAGES-1];
    logic [PW-1:0]     r_mplier [STAGES-1];
    CDB_ENTRY          r_out;

    logic [STAGES-1:0] w_free;
    logic              w_take;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [PW-1:0]     w_a_ext;
    logic [PW-1:0]     w_b_ext;
    logic [PW-1:0]     w_pp0;
    logic [PW-1:0]     w_pp     [STAGES-1];
    logic [XLEN-1:0]   w_res;

    // A stage is free if it or any stage above it is empty, or the top is granted
    always_comb begin
        logic v_all;
        v_all  = 1'b1;
        w_take = cdb_grant & r_valid[LAST];
        w_free = '0;
        for (int k = LAST; k >= 0; k--) begin
            v_all     = v_all & r_valid[k];
            w_free[k] = w_take | ~v_all;
        end
    end

    // Operand extension and per-stage partial-product accumulation
    always_comb begin
        w_a_sgn = (issue_func != 2'd3);
        w_b_sgn = ~issue_func[1];
        w_a_ext = {{XLEN{w_a_sgn & issue_rs1[XLEN-1]}}, issue_rs1};
        w_b_ext = {{XLEN{w_b_sgn & issue_rs2[XLEN-1]}}, issue_rs2};
        w_pp0   = w_a_ext * {{(PW-SL){1'b0}}, w_b_ext[SL-1:0]};
        for (int k = 0; k < LAST; k++) begin
            w_pp[k] = r_acc[k]
                    + r_mcand[k] * {{(PW-SL){1'b0}}, r_mplier[k][SL-1:0]};
        end
        w_res = (r_func[LAST] == 2'd0) ? r_acc[LAST][XLEN-1:0]
                                       : r_acc[LAST][PW-1:XLEN];
    end

    // Stage registers: shift into free stages, flush clears all valids
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_tag[k]  <= '0;
                r_func[k] <= '0;
                r_acc[k]  <= '0;
            end
            for (int k = 0; k < LAST; k++) begin
                r_mcand[k]  <= '0;
                r_mplier[k] <= '0;
            end
        end else begin
            if (w_free[0]) begin
                r_valid[0]  <= issue_valid;
                r_tag[0]    <= issue_tag;
                r_func[0]   <= issue_func;
                r_acc[0]    <= w_pp0;
                r_mcand[0]  <= w_a_ext << SL;
                r_mplier[0] <= w_b_ext >> SL;
            end
            for (int k = 1; k < LAST; k++) begin
                if (w_free[k]) begin
                    r_valid[k]  <= r_valid[k-1];
                    r_tag[k]    <= r_tag[k-1];
                    r_func[k]   <= r_func[k-1];
                    r_acc[k]    <= w_pp[k-1];
                    r_mcand[k]  <= r_mcand[k-1] << SL;
                    r_mplier[k] <= r_mplier[k-1] >> SL;
                end
            end
            if (w_free[LAST]) begin
                r_valid[LAST] <= r_valid[LAST-1];
                r_tag[LAST]   <= r_tag[LAST-1];
                r_func[LAST]  <= r_func[LAST-1];
                r_acc[LAST]   <= w_pp[LAST-1];
            end
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

    // Broadcast register mirrors the CDB's registered grant
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
        end else if (w_take) begin
            r_out <= '{valid: 1'b1, tag: r_tag[LAST], data: w_res};
        end else begin
            r_out <= '0;
        end
    end

    assign issue_ready = w_free[0];
    assign cdb_request = r_valid[LAST];
    assign fu_output   = r_out;
endmodule

// File: tb/tb_mult_fu_cdb_stage.sv
// Scoreboard bench for mult_fu_cdb_stage.
// Directed scenarios plus random traffic against an arithmetic model.
module tb_mult_fu_cdb_stage;
    import mult_fu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [31:0] issue_rs1 = '0;
    logic [31:0] issue_rs2 = '0;
    logic [1:0]  issue_func = '0;
    logic [5:0]  issue_tag = '0;
    logic        flush = 1'b0;
    logic        cdb_request;
    logic        cdb_grant = 1'b0;
    CDB_ENTRY    fu_output;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    mult_fu_cdb_stage dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_func  (issue_func),
        .issue_tag   (issue_tag),
        .flush       (flush),
        .cdb_request (cdb_request),
        .cdb_grant   (cdb_grant),
        .fu_output   (fu_output)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sbv;
        longint      p;
        logic [63:0] pu;
        sa  = (f == 2'd3) ? longint'({32'b0, a}) : longint'($signed(a));
        sbv = f[1] ? longint'({32'b0, b}) : longint'($signed(b));
        p   = sa * sbv;
        pu  = p;
        return (f == 2'd0) ? pu[31:0] : pu[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // Record accepted ops; flush keeps only an op granted in the same cycle
    always @(posedge clock or negedge reset) begin : trk
        exp_t keep;
        if (!reset) begin
            sb.delete();
        end else if (flush) begin
            if (cdb_grant && cdb_request && sb.size() > 0) begin
                keep = sb[0];
                sb.delete();
                sb.push_back(keep);
            end else begin
                sb.delete();
            end
        end else if (issue_valid && issue_ready) begin
            sb.push_back('{issue_tag,
                           ref_mul(issue_func, issue_rs1, issue_rs2)});
        end
    end

    // Every broadcast must match the oldest outstanding op
    always @(negedge clock) begin : mon
        exp_t e;
        if (reset && fu_output.valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bcast_unexpected: got tag %0d, want none",
                         fu_output.tag);
            end else begin
                e = sb.pop_front();
                check("bcast_tag", 64'(fu_output.tag), 64'(e.tag));
                check("bcast_data", 64'(fu_output.data), 64'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] t);
        issue_valid = 1'b1;
        issue_func  = f;
        issue_rs1   = a;
        issue_rs2   = b;
        issue_tag   = t;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic lat_check(input logic [1:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [5:0] t,
                             input logic [31:0] want);
        cdb_grant = 1'b1;
        set_op(f, a, b, t);
        #1;
        check("lat_ready_pre", 64'(issue_ready), 64'd1);
        step();
        idle();
        for (int c = 0; c < 6; c++) begin
            check("lat_req", 64'(cdb_request), 64'(c == 3));
            check("lat_valid", 64'(fu_output.valid), 64'(c == 4));
            check("lat_ready", 64'(issue_ready), 64'd1);
            if (c == 4) begin
                check("lat_tag", 64'(fu_output.tag), 64'(t));
                check("lat_data", 64'(fu_output.data), 64'(want));
            end
            step();
        end
    endtask

    task automatic run_one(input logic [1:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [5:0] t,
                           input logic [31:0] want);
        bit got;
        got = 1'b0;
        cdb_grant = 1'b1;
        set_op(f, a, b, t);
        step();
        idle();
        for (int i = 0; i < 20 && !got; i++) begin
            if (fu_output.valid) begin
                got = 1'b1;
                check("dir_tag", 64'(fu_output.tag), 64'(t));
                check("dir_data", 64'(fu_output.data), 64'(want));
            end
            step();
        end
        if (!got) check("dir_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int   cnt;
        int   first;
        int   last;
        int   nxt;
        logic acc_now;

        // reset state
        reset = 1'b0;
        step();
        check("rst_ready", 64'(issue_ready), 64'd1);
        check("rst_req", 64'(cdb_request), 64'd0);
        check("rst_out", 64'(fu_output), 64'd0);
        reset = 1'b1;
        step();

        // single MUL latency
        lat_check(2'd0, 32'd7, 32'd6, 6'd5, 32'd42);

        // result selection corners
        run_one(2'd1, 32'h8000_0000, 32'h8000_0000, 6'd11, 32'h4000_0000);
        run_one(2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 6'd12, 32'hFFFF_FFFF);
        run_one(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd13, 32'hFFFF_FFFE);
        run_one(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd14, 32'h0000_0001);

        // backpressure: six back-to-back ops, grant withheld
        cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(2'($urandom), rnd_opnd(), rnd_opnd(), 6'(20 + i));
            #1;
            check("bp_ready_fill", 64'(issue_ready), 64'd1);
            step();
        end
        set_op(2'($urandom), rnd_opnd(), rnd_opnd(), 6'd24);
        #1;
        check("bp_ready_full", 64'(issue_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_req_hold", 64'(cdb_request), 64'd1);
            check("bp_no_bcast", 64'(fu_output.valid), 64'd0);
            check("bp_ready_low", 64'(issue_ready), 64'd0);
        end
        cdb_grant = 1'b1;
        nxt = 4;
        cnt = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            acc_now = issue_valid && issue_ready;
            step();
            if (acc_now) begin
                nxt++;
                if (nxt < 6)
                    set_op(2'($urandom), rnd_opnd(), rnd_opnd(), 6'(20 + nxt));
                else
                    idle();
            end
            if (fu_output.valid) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        check("bp_bcast_cnt", 64'(cnt), 64'd6);
        check("bp_bcast_contig", 64'(last - first), 64'd5);

        // bubble collapse
        cdb_grant = 1'b0;
        set_op(2'd0, 32'd3, 32'd3, 6'd1);
        step();
        idle();
        step();
        set_op(2'd0, 32'd4, 32'd4, 6'd2);
        #1;
        check("bub_ready_2", 64'(issue_ready), 64'd1);
        step();
        idle();
        repeat (3) step();
        check("bub_ready_idle", 64'(issue_ready), 64'd1);
        check("bub_req", 64'(cdb_request), 64'd1);
        set_op(2'd3, 32'd5, 32'd5, 6'd3);
        #1;
        check("bub_ready_3", 64'(issue_ready), 64'd1);
        step();
        set_op(2'd1, 32'd6, 32'd6, 6'd4);
        #1;
        check("bub_ready_4", 64'(issue_ready), 64'd1);
        step();
        idle();
        check("bub_ready_full", 64'(issue_ready), 64'd0);
        cdb_grant = 1'b1;
        repeat (10) step();

        // flush with a same-cycle grant and a same-cycle issue
        cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(2'd0, 32'(100 + i), 32'd3, 6'(9 + i));
            step();
        end
        idle();
        repeat (4) step();
        check("fl_req_pre", 64'(cdb_request), 64'd1);
        flush = 1'b1;
        cdb_grant = 1'b1;
        set_op(2'd0, 32'd1, 32'd1, 6'd12);
        step();
        flush = 1'b0;
        idle();
        check("fl_bcast_valid", 64'(fu_output.valid), 64'd1);
        check("fl_bcast_tag", 64'(fu_output.tag), 64'd9);
        check("fl_bcast_data", 64'(fu_output.data), 64'd300);
        check("fl_req_off", 64'(cdb_request), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("fl_quiet_req", 64'(cdb_request), 64'd0);
            check("fl_quiet_out", 64'(fu_output.valid), 64'd0);
        end
        check("fl_ready", 64'(issue_ready), 64'd1);

        // reset during a stall with a broadcast in flight
        cdb_grant = 1'b0;
        set_op(2'd0, 32'd2, 32'd2, 6'd30);
        step();
        set_op(2'd0, 32'd3, 32'd3, 6'd31);
        step();
        idle();
        repeat (4) step();
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
        check("rs_pre_valid", 64'(fu_output.valid), 64'd1);
        check("rs_pre_req", 64'(cdb_request), 64'd1);
        reset = 1'b0;
        #1;
        check("rs_req_drop", 64'(cdb_request), 64'd0);
        check("rs_valid_drop", 64'(fu_output.valid), 64'd0);
        step();
        reset = 1'b1;
        step();
        lat_check(2'd0, 32'd3, 32'd5, 6'd33, 32'd15);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            flush     = ($urandom_range(0, 99) < 3);
            cdb_grant = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 70)
                set_op(2'($urandom), rnd_opnd(), rnd_opnd(), 6'($urandom));
            else
                idle();
            step();
        end
        flush = 1'b0;
        idle();
        cdb_grant = 1'b1;
        repeat (12) step();
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_req", 64'(cdb_request), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mult_fu_cdb_stage.md
Name: mult_fu_cdb_stage

Overview:
- Pipelined integer multiply functional unit that sits directly upstream of the CDB arbiter/broadcast block.
- Accepts issued MUL/MULH/MULHSU/MULHU ops and computes the product over STAGES pipeline registers.
- Raises a CDB request from its final stage and holds the result until granted.
- On a grant, drives the result on its fu_outputs slot exactly one cycle later, matching the CDB's registered grant bus.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 4, pipeline depth including the final (request) stage; legal 2..8, must divide 2*XLEN.
- TAG_W, 6, physical register tag width; must match CDB_ENTRY.tag.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  op presented this cycle.
- issue_ready  out  1  unit can accept; transfer when issue_valid && issue_ready.
- issue_rs1  in  XLEN  operand A.
- issue_rs2  in  XLEN  operand B.
- issue_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- issue_tag  in  TAG_W  destination physical tag.
- flush  in  1  mispredict squash of all in-flight ops.
- cdb_request  out  1  this unit's bit of mult_requests.
- cdb_grant  in  1  this unit's bit of mult_grants, same cycle as request.
- fu_output  out  CDB_ENTRY  {valid, tag, data}; feeds the CDB fu_outputs slot.

Behaviour:
- Reset (reset==0, async):
  - all stage valid bits clear; broadcast register clear.
  - issue_ready=1, cdb_request=0, fu_output='0.
- Operand extension to 2*XLEN:
  - MUL/MULH: both signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
- Partial products: each stage accumulates a (2*XLEN/STAGES)-bit slice of operand B into a 2*XLEN accumulator. All arithmetic is modulo 2^(2*XLEN).
- Result selection:
  - MUL returns product[XLEN-1:0].
  - All others return product[2*XLEN-1:XLEN].
- Stage k holds valid, tag, func, multiplicand, remaining multiplier, accumulator.
  - Stage STAGES-1 is the request stage.
  - It holds the final result and asserts cdb_request = its valid bit (combinational from the register).
- Advance rule (bubble-collapsing):
  - Request stage frees when granted (cdb_grant && cdb_request) or when empty.
  - Stage k advances iff stage k+1 is empty or freeing this cycle.
  - issue_ready = stage0 empty or stage0 advancing (combinational, no issue_valid dependence).
- Latency with no backpressure: accept in cycle 0 → cdb_request in cycle STAGES-1 → fu_output.valid in cycle STAGES.
- Throughput: 1 op/cycle with continuous grants.
- Broadcast register:
  - At the edge after a grant cycle, it loads {1, tag, result} from the request stage.
  - Otherwise it loads valid=0.
  - fu_output is the broadcast register, so valid is high for exactly one cycle per grant.
- Stall: request stage valid and cdb_grant=0 → request stage and its contents hold unchanged; cdb_request stays high every cycle until granted.
- cdb_grant without cdb_request is ignored; no broadcast, no state change.
- flush:
  - At the next edge, all stage valid bits clear.
  - An op accepted the same cycle is discarded.
  - A grant in the flush cycle still produces its broadcast (the CDB has already committed the slot).
  - cdb_request deasserts the cycle after flush.
- Simultaneous grant + new issue with a full pipe: the grant frees the request stage, the whole pipe shifts, and the issue is accepted in the same cycle.
- Reset mid-operation discards everything immediately; no partial broadcast.

Test Plan:
- Reset then single MUL 7×6, tag 5, grant held high → cdb_request cycle 3, fu_output {1,5,42} cycle 4 only; issue_ready=1 throughout.
- MULH 0x80000000×0x80000000 → data 0x40000000. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MUL low 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Grant withheld 3 cycles, 6 back-to-back issues:
  - request stays high and the result stays stable.
  - issue_ready drops after 4 ops are in flight; ops 5 and 6 stall.
  - After the grants resume, all 6 tags broadcast in issue order, one per cycle.
- Bubble collapse: issue tags 1,_,2 with grant low → both ops packed in the top two stages; issue_ready stays 1 until 4 valid.
- Flush with 3 ops in flight and a grant for tag 9 in the same cycle → tag 9 broadcasts next cycle; no further request; pipe empty.
- Assert reset mid-stall with the request stage valid → cdb_request and fu_output.valid drop asynchronously; after release, the first new op has normal latency.
